// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with stall hold, redirect and in-flight drop
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] inst,
    output logic        bubble,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [1:0] {FETCH, HELD, DROP} state_t;

    localparam logic [31:0] RESET_PC_AL = RESET_PC & ~32'h3;

    state_t      state, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_buf, drop_addr, cnt_q;
    logic [31:0] target;
    logic        req_raw;

    assign target    = redirect_pc & ~32'h3;
    assign pc        = pc_q;
    assign pc4       = pc_q + 32'd4;
    assign fetch_cnt = cnt_q;
    assign imem_req  = req_raw & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH;
        else      state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            FETCH: begin
                if (redirect && !imem_ready)             state_d = DROP;
                else if (!redirect && imem_ready && stall) state_d = HELD;
                else                                     state_d = FETCH;
            end
            HELD:    if (redirect || !stall) state_d = FETCH;
            DROP:    if (imem_ready)         state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        req_raw   = 1'b1;
        imem_addr = pc_q;
        inst      = NOP_INST;
        bubble    = 1'b1;
        case (state)
            FETCH: begin
                if (imem_ready && !redirect) begin
                    inst   = imem_rdata;
                    bubble = 1'b0;
                end
            end
            HELD: begin
                req_raw = 1'b0;
                inst    = inst_buf;
                bubble  = 1'b0;
            end
            DROP: imem_addr = drop_addr;
            default: ;
        endcase
    end

    // A redirect always wins; otherwise the PC advances only when the slot is delivered.
    always_comb begin
        pc_d = pc_q;
        if (redirect)
            pc_d = target;
        else if (state == FETCH && imem_ready && !stall)
            pc_d = pc_q + 32'd4;
        else if (state == HELD && !stall)
            pc_d = pc_q + 32'd4;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= RESET_PC_AL;
            inst_buf  <= NOP_INST;
            drop_addr <= 32'd0;
            cnt_q     <= 32'd0;
        end else begin
            pc_q <= pc_d;
            if (state == FETCH && redirect && !imem_ready)
                drop_addr <= pc_q;
            if (state == FETCH && imem_ready && stall && !redirect)
                inst_buf <= imem_rdata;
            if (!bubble && !stall && !redirect)
                cnt_q <= cnt_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, redirect, imem_ready;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, bubble;
    logic [31:0] imem_addr, pc, pc4, inst, fetch_cnt;
    logic        use_ovr;
    logic [31:0] ovr;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    // Memory returns a word tagged with its own address unless overridden.
    always_comb imem_rdata = use_ovr ? ovr : (32'hA000_0000 | imem_addr);

    if_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .pc(pc), .pc4(pc4),
        .inst(inst), .bubble(bubble), .fetch_cnt(fetch_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        stall = 0; redirect = 0; redirect_pc = 0; imem_ready = 1; use_ovr = 0; ovr = 0;
        rst = 0;
        settle();
        tick();
        tick();
        rst = 1;
    endtask

    initial begin
        do_reset();
        rst = 0;
        settle();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc4", pc4, 32'h4);
        chk("rst_cnt", fetch_cnt, 32'd0);
        tick();
        rst = 1;

        // zero-wait fetch of 0,4,8,C
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("seq_pc", pc, 32'(i * 4));
            chk("seq_bubble", {31'd0, bubble}, 32'd0);
            chk("seq_inst", inst, 32'hA000_0000 | 32'(i * 4));
            tick();
        end
        chk("seq_cnt", fetch_cnt, 32'd4);

        // wait states at pc=8
        do_reset();
        tick(); tick();
        imem_ready = 0;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("wait_bubble", {31'd0, bubble}, 32'd1);
            chk("wait_addr", imem_addr, 32'h8);
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            tick();
        end
        imem_ready = 1;
        settle();
        chk("wait_pc", pc, 32'h8);
        chk("wait_inst", inst, 32'hA000_0008);
        chk("wait_bubble_done", {31'd0, bubble}, 32'd0);
        tick();
        chk("wait_cnt", fetch_cnt, 32'd3);
        chk("wait_pc_next", pc, 32'hC);

        // stall capture at pc=4
        do_reset();
        tick();
        stall = 1; use_ovr = 1; ovr = 32'hDEAD_BEEF;
        settle();
        chk("stall_first_inst", inst, 32'hDEAD_BEEF);
        tick();
        use_ovr = 0;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("held_req", {31'd0, imem_req}, 32'd0);
            chk("held_inst", inst, 32'hDEAD_BEEF);
            chk("held_pc", pc, 32'h4);
            chk("held_bubble", {31'd0, bubble}, 32'd0);
            tick();
        end
        stall = 0;
        tick();
        chk("held_release_pc", pc, 32'h8);
        chk("held_release_cnt", fetch_cnt, 32'd2);

        // redirect while a request to 0xC is pending
        do_reset();
        tick(); tick(); tick();
        imem_ready = 0; redirect = 1; redirect_pc = 32'h100;
        settle();
        chk("redir_bubble", {31'd0, bubble}, 32'd1);
        chk("redir_addr", imem_addr, 32'hC);
        tick();
        redirect = 0;
        settle();
        chk("drop_addr", imem_addr, 32'hC);
        chk("drop_req", {31'd0, imem_req}, 32'd1);
        chk("drop_pc", pc, 32'h100);
        tick();
        imem_ready = 1;
        settle();
        chk("drop_done_addr", imem_addr, 32'hC);
        chk("drop_done_inst", inst, 32'h0000_0013);
        chk("drop_done_bubble", {31'd0, bubble}, 32'd1);
        tick();
        settle();
        chk("after_drop_addr", imem_addr, 32'h100);
        chk("after_drop_inst", inst, 32'hA000_0100);
        chk("after_drop_cnt", fetch_cnt, 32'd3);
        tick();

        // redirect beats stall, target low bits cleared
        redirect = 1; stall = 1; redirect_pc = 32'h203;
        settle();
        chk("rs_bubble", {31'd0, bubble}, 32'd1);
        chk("rs_inst", inst, 32'h0000_0013);
        tick();
        redirect = 0; stall = 0;
        settle();
        chk("rs_pc", pc, 32'h200);
        chk("rs_bubble_after", {31'd0, bubble}, 32'd0);
        chk("rs_cnt", fetch_cnt, 32'd4);
        tick();

        // pc4 wraps at top of address space
        redirect = 1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 0;
        settle();
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc4, 32'h0);
        tick();

        // reset asserted in DROP
        imem_ready = 0; redirect = 1; redirect_pc = 32'h300;
        tick();
        redirect = 0;
        settle();
        chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
        rst = 0;
        settle();
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_cnt", fetch_cnt, 32'd0);
        tick();
        imem_ready = 1;
        rst = 1;
        settle();
        chk("post_rst_addr", imem_addr, 32'h0);
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
        chk("post_rst_bubble", {31'd0, bubble}, 32'd0);
        tick();
        chk("post_rst_pc", pc, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
